snoop_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared snooping bus between `NPROC` processor caches. It grants the bus to one requesting cache and broadcasts that cache's MESI bus message (read miss, write miss, invalidate) to all snoopers. It then collects their shared and writeback responses over a fixed snoop window, waits for memory when a modified line must be written back, and returns a completion message with the shared flag to the owner. It sits between the `processador` instances and main memory.

---
 rtl/snoop_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared snoop bus: broadcast, snoop window, optional writeback wait, completion.
// Grant-to-done is 2+SNOOP_CYCLES cycles without writeback; requesters hold req until done, and memory stalls via mem_ready.
module snoop_bus_arbiter #(
  parameter int NPROC        = 4,
  parameter int SNOOP_CYCLES = 2,
  localparam int IW          = $clog2(NPROC)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NPROC-1:0]   req,
  input  logic [NPROC*7-1:0] req_msg,
  output logic [NPROC-1:0]   gnt,
  output logic               bus_valid,
  output logic [7:0]         bus_msg,
  output logic [IW-1:0]      bus_src,
  input  logic [NPROC-1:0]   snoop_shared,
  input  logic [NPROC-1:0]   snoop_wb,
  input  logic               mem_ready,
  output logic [NPROC-1:0]   done,
  output logic [7:0]         rsp_msg,
  output logic               busy
);

  localparam int CW = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SNOOP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BCAST  = 3'd1,
    ST_SNOOP  = 3'd2,
    ST_WBWAIT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     owner_q;
  logic [6:0]        msg_q;
  logic [CW-1:0]     cnt_q;
  logic              shared_q;
  logic              wb_q;
  logic [NPROC-1:0]  gnt_q;
  logic              busy_q;
  logic              bus_valid_q;
  logic [7:0]        bus_msg_q;
  logic [NPROC-1:0]  done_q;
  logic [7:0]        rsp_q;

  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [NPROC-1:0]  pick_oh;
  logic [6:0]        pick_msg;
  logic [IW:0]       rr_sum;
  logic [IW-1:0]     rr_idx;
  logic [IW-1:0]     ptr_d;
  logic              acc_shared_d;
  logic              acc_wb_d;
  logic              snoop_cmd;
  logic              wb_cmd;

  // Search starts at the pointer and wraps modulo NPROC; first requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    pick_msg = '0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int i = 0; i < NPROC; i++) begin
      rr_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (rr_sum >= (IW+1)'(NPROC)) rr_sum = rr_sum - (IW+1)'(NPROC);
      rr_idx = rr_sum[IW-1:0];
      if (!pick_vld && req[rr_idx]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx;
      end
    end
    for (int i = 0; i < NPROC; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_oh[i] = 1'b1;
        pick_msg   = req_msg[7*i +: 7];
      end
    end
  end

  // gnt_q is the owner's one-hot, so it doubles as the self-snoop mask.
  always_comb begin
    acc_shared_d = shared_q | (|(snoop_shared & ~gnt_q));
    acc_wb_d     = wb_q | (|(snoop_wb & ~gnt_q));
    snoop_cmd    = (msg_q[6:4] == 3'b000) || (msg_q[6:4] == 3'b001) || (msg_q[6:4] == 3'b010);
    wb_cmd       = (msg_q[6:4] == 3'b000) || (msg_q[6:4] == 3'b001);
    ptr_d        = (owner_q == IW'(NPROC - 1)) ? '0 : owner_q + 1'b1;
  end

  // A write-miss owner ends in M, so it never reports shared.
  function automatic logic [7:0] mk_rsp(input logic sh, input logic [6:0] m);
    return {sh & (m[6:4] != 3'b001), 3'b101, m[3:0]};
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      msg_q       <= '0;
      cnt_q       <= '0;
      shared_q    <= 1'b0;
      wb_q        <= 1'b0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_msg_q   <= '0;
      done_q      <= '0;
      rsp_q       <= '0;
    end else begin
      bus_valid_q <= 1'b0;
      bus_msg_q   <= '0;
      done_q      <= '0;
      rsp_q       <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q     <= ST_BCAST;
            owner_q     <= pick_idx;
            gnt_q       <= pick_oh;
            msg_q       <= pick_msg;
            busy_q      <= 1'b1;
            bus_valid_q <= 1'b1;
            bus_msg_q   <= {1'b0, pick_msg};
            shared_q    <= 1'b0;
            wb_q        <= 1'b0;
            cnt_q       <= '0;
          end
        end
        ST_BCAST: begin
          if (snoop_cmd) begin
            state_q <= ST_SNOOP;
          end else begin
            state_q <= ST_DONE;
            done_q  <= gnt_q;
            rsp_q   <= mk_rsp(1'b0, msg_q);
          end
        end
        ST_SNOOP: begin
          shared_q <= acc_shared_d;
          wb_q     <= acc_wb_d;
          if (cnt_q == CNT_LAST) begin
            if (acc_wb_d && wb_cmd) begin
              state_q <= ST_WBWAIT;
            end else begin
              state_q <= ST_DONE;
              done_q  <= gnt_q;
              rsp_q   <= mk_rsp(acc_shared_d, msg_q);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WBWAIT: begin
          if (mem_ready) begin
            state_q <= ST_DONE;
            done_q  <= gnt_q;
            rsp_q   <= mk_rsp(shared_q, msg_q);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign bus_valid = bus_valid_q;
  assign bus_msg   = bus_msg_q;
  assign bus_src   = owner_q;
  assign done      = done_q;
  assign rsp_msg   = rsp_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: directed scenarios with literal expectations, then random traffic against a transaction model.
module tb_snoop_bus_arbiter;
  localparam int NPROC = 4;
  localparam int S     = 2;
  localparam int IW    = 2;

  logic               clock = 1'b0;
  logic               resetn = 1'b1;
  logic [NPROC-1:0]   req = '0;
  logic [NPROC*7-1:0] req_msg = '0;
  logic [NPROC-1:0]   gnt;
  logic               bus_valid;
  logic [7:0]         bus_msg;
  logic [IW-1:0]      bus_src;
  logic [NPROC-1:0]   snoop_shared = '0;
  logic [NPROC-1:0]   snoop_wb = '0;
  logic               mem_ready = 1'b0;
  logic [NPROC-1:0]   done;
  logic [7:0]         rsp_msg;
  logic               busy;

  snoop_bus_arbiter #(.NPROC(NPROC), .SNOOP_CYCLES(S)) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_msg(req_msg),
    .gnt(gnt), .bus_valid(bus_valid), .bus_msg(bus_msg), .bus_src(bus_src),
    .snoop_shared(snoop_shared), .snoop_wb(snoop_wb), .mem_ready(mem_ready),
    .done(done), .rsp_msg(rsp_msg), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NPROC-1:0] oh(input int i);
    return NPROC'(1) << i;
  endfunction

  // Transaction model: m_age counts cycles since the grant (1 = broadcast cycle).
  bit         m_act, m_fin, m_wait, m_sh, m_wb;
  int         m_own, m_age, m_ptr;
  logic [6:0] m_msg;

  task automatic model_reset();
    m_act = 0; m_fin = 0; m_wait = 0; m_sh = 0; m_wb = 0;
    m_own = 0; m_age = 0; m_ptr = 0; m_msg = '0;
  endtask

  task automatic model_step();
    logic [2:0]       cmd;
    logic [NPROC-1:0] others;
    int               idx;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (!m_act) begin
      for (int k = 0; k < NPROC; k++) begin
        idx = (m_ptr + k) % NPROC;
        if (!m_act && req[idx]) begin
          m_act = 1; m_own = idx; m_msg = 7'(req_msg >> (7 * idx));
          m_age = 1; m_sh = 0; m_wb = 0; m_wait = 0; m_fin = 0;
        end
      end
    end else if (m_fin) begin
      m_act = 0; m_fin = 0;
      m_ptr = (m_own + 1) % NPROC;
    end else begin
      cmd    = m_msg[6:4];
      others = ~oh(m_own);
      if (m_age == 1 && cmd > 3'd2) begin
        m_fin = 1;
      end else if (m_age >= 2 && m_age <= S + 1) begin
        m_sh = m_sh | (|(snoop_shared & others));
        m_wb = m_wb | (|(snoop_wb & others));
        if (m_age == S + 1) begin
          if (m_wb && cmd <= 3'd1) m_wait = 1;
          else m_fin = 1;
        end
      end else if (m_wait && mem_ready) begin
        m_wait = 0; m_fin = 1;
      end
      m_age++;
    end
  endtask

  always @(negedge clock) begin : cmp
    logic bv;
    bv = m_act && (m_age == 1);
    check("gnt", 32'(gnt), m_act ? 32'(oh(m_own)) : 32'd0);
    check("busy", 32'(busy), 32'(m_act));
    check("bus_valid", 32'(bus_valid), 32'(bv));
    check("bus_msg", 32'(bus_msg), bv ? 32'({1'b0, m_msg}) : 32'd0);
    if (bv) check("bus_src", 32'(bus_src), 32'(m_own));
    check("done", 32'(done), m_fin ? 32'(oh(m_own)) : 32'd0);
    check("rsp_msg", 32'(rsp_msg),
          m_fin ? 32'({m_sh && (m_msg[6:4] != 3'b001), 3'b101, m_msg[3:0]}) : 32'd0);
  end

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // Starts in the IDLE cycle with req already driven; returns in the done cycle.
  task automatic run_txn(input int mr_cyc, output int bv_cyc, output logic [7:0] bmsg,
                         output logic [IW-1:0] bsrc, output int dn_cyc,
                         output logic [NPROC-1:0] dn, output logic [7:0] rsp);
    int cyc;
    cyc = 0; bv_cyc = -1; dn_cyc = -1; bmsg = '0; bsrc = '0; dn = '0; rsp = '0;
    while (dn_cyc < 0 && cyc < 40) begin
      mem_ready = (cyc >= mr_cyc);
      tick();
      cyc++;
      if (bus_valid) begin bv_cyc = cyc; bmsg = bus_msg; bsrc = bus_src; end
      if (done != '0) begin dn_cyc = cyc; dn = done; rsp = rsp_msg; end
    end
    check("txn_done_seen", 32'(dn_cyc >= 0), 32'd1);
  endtask

  task automatic set_msg(input int i, input logic [6:0] m);
    req_msg[7*i +: 7] = m;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_bus_valid"}, 32'(bus_valid), 32'd0);
    check({tag, "_bus_msg"}, 32'(bus_msg), 32'd0);
    check({tag, "_bus_src"}, 32'(bus_src), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rsp_msg"}, 32'(rsp_msg), 32'd0);
  endtask

  logic [2:0] cmd_tbl [10];
  int exp_src [5];

  initial begin
    int               bv_cyc, dn_cyc;
    logic [7:0]       bmsg, rsp;
    logic [IW-1:0]    bsrc;
    logic [NPROC-1:0] dn;

    cmd_tbl = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd5, 3'd3, 3'd6, 3'd7};
    exp_src = '{0, 1, 2, 3, 0};
    model_reset();
    #1 resetn = 1'b0;
    @(negedge clock); #1;
    check_all_zero("reset");
    tick();
    resetn = 1'b1;

    // Single request, no sharers.
    req = 4'b0001; set_msg(0, 7'b000_1_101);
    run_txn(100, bv_cyc, bmsg, bsrc, dn_cyc, dn, rsp);
    check("t1_bv_cycle", 32'(bv_cyc), 32'd1);
    check("t1_bus_msg", 32'(bmsg), 32'h0D);
    check("t1_bus_src", 32'(bsrc), 32'd0);
    check("t1_done_cycle", 32'(dn_cyc), 32'd4);
    check("t1_done", 32'(dn), 32'b0001);
    check("t1_rsp", 32'(rsp), 32'h5D);
    req = '0; tick();

    // Shared read seen from another cache.
    req = 4'b0100; set_msg(2, 7'b000_0_011); snoop_shared = 4'b0010;
    run_txn(100, bv_cyc, bmsg, bsrc, dn_cyc, dn, rsp);
    check("t2_done_cycle", 32'(dn_cyc), 32'd4);
    check("t2_done", 32'(dn), 32'b0100);
    check("t2_rsp", 32'(rsp), 32'hD3);
    req = '0; tick();

    // Only the owner's own shared bit: masked off.
    req = 4'b0100; snoop_shared = 4'b0100;
    run_txn(100, bv_cyc, bmsg, bsrc, dn_cyc, dn, rsp);
    check("t3_rsp", 32'(rsp), 32'h53);
    req = '0; snoop_shared = '0; tick();

    // Write miss with writeback, memory low for 3 cycles.
    req = 4'b0010; set_msg(1, 7'b001_1_010); snoop_wb = 4'b1000; snoop_shared = 4'b1111;
    run_txn(7, bv_cyc, bmsg, bsrc, dn_cyc, dn, rsp);
    check("t4_done_cycle", 32'(dn_cyc), 32'd8);
    check("t4_done", 32'(dn), 32'b0010);
    check("t4_rsp", 32'(rsp), 32'h5A);
    req = '0; snoop_wb = '0; snoop_shared = '0; tick();

    // Reserved cmd skips the snoop window.
    req = 4'b0001; set_msg(0, 7'b110_0_000);
    run_txn(100, bv_cyc, bmsg, bsrc, dn_cyc, dn, rsp);
    check("t5_bus_msg", 32'(bmsg), 32'h60);
    check("t5_done_cycle", 32'(dn_cyc), 32'd2);
    check("t5_rsp", 32'(rsp), 32'h50);
    req = '0; tick();

    // Async reset during the writeback wait.
    req = 4'b0010; set_msg(1, 7'b001_0_110); snoop_wb = 4'b1000; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t6_busy_before_reset", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check_all_zero("t6_async");
    model_reset();
    req = '0; snoop_wb = '0;
    tick();
    resetn = 1'b1;
    req = 4'b1000; set_msg(3, 7'b000_1_111);
    run_txn(100, bv_cyc, bmsg, bsrc, dn_cyc, dn, rsp);
    check("t6_src_after_reset", 32'(bsrc), 32'd3);
    check("t6_done", 32'(dn), 32'b1000);
    check("t6_rsp", 32'(rsp), 32'h5F);
    req = '0; tick();

    // Round robin with all requesting; wb on an invalidate is ignored.
    for (int i = 0; i < NPROC; i++) set_msg(i, 7'b010_1_001);
    req = 4'b1111; snoop_wb = 4'b1111; snoop_shared = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      run_txn(100, bv_cyc, bmsg, bsrc, dn_cyc, dn, rsp);
      check("rr_src", 32'(bsrc), 32'(exp_src[t]));
      check("rr_done", 32'(dn), 32'(oh(exp_src[t])));
      check("rr_done_cycle", 32'(dn_cyc), 32'd4);
      check("rr_rsp", 32'(rsp), 32'hD9);
      tick();
    end
    req = '0; snoop_wb = '0; snoop_shared = '0; tick(); tick();

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NPROC; i++) begin
        if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
        if ($urandom_range(2) == 0) set_msg(i, {cmd_tbl[$urandom_range(9)], 4'($urandom)});
      end
      if (m_act && !m_fin && $urandom_range(49) == 0) req[m_own] = 1'b0;
      snoop_shared = NPROC'($urandom);
      snoop_wb     = ($urandom_range(3) == 0) ? NPROC'($urandom) : '0;
      mem_ready    = ($urandom_range(2) != 0);
      if ($urandom_range(499) == 0) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
      end else begin
        tick();
        if (m_fin && $urandom_range(1) == 0) req[m_own] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
